// File: rtl/ps2_key_state_tracker_pkg.sv
// Shared constants for the PS/2 key state tracker: vector width, key index
// map, Set-2 prefix bytes and the prefix-tracking FSM state type.
package ps2_key_state_tracker_pkg;

    localparam int unsigned NUMBEROFKEYBOARDINPUTS = 30;
    localparam int unsigned KEY_IDX_W              = 5;

    localparam logic [KEY_IDX_W-1:0] KEY_0          = 5'd0;
    localparam logic [KEY_IDX_W-1:0] KEY_1          = 5'd1;
    localparam logic [KEY_IDX_W-1:0] KEY_2          = 5'd2;
    localparam logic [KEY_IDX_W-1:0] KEY_3          = 5'd3;
    localparam logic [KEY_IDX_W-1:0] KEY_4          = 5'd4;
    localparam logic [KEY_IDX_W-1:0] KEY_5          = 5'd5;
    localparam logic [KEY_IDX_W-1:0] KEY_6          = 5'd6;
    localparam logic [KEY_IDX_W-1:0] KEY_7          = 5'd7;
    localparam logic [KEY_IDX_W-1:0] KEY_8          = 5'd8;
    localparam logic [KEY_IDX_W-1:0] KEY_9          = 5'd9;
    localparam logic [KEY_IDX_W-1:0] KEY_TILDE      = 5'd10;
    localparam logic [KEY_IDX_W-1:0] KEY_MINUS      = 5'd11;
    localparam logic [KEY_IDX_W-1:0] KEY_EQUAL      = 5'd12;
    localparam logic [KEY_IDX_W-1:0] KEY_BACKSPACE  = 5'd13;
    localparam logic [KEY_IDX_W-1:0] KEY_TAB        = 5'd14;
    localparam logic [KEY_IDX_W-1:0] KEY_Q          = 5'd15;
    localparam logic [KEY_IDX_W-1:0] KEY_W          = 5'd16;
    localparam logic [KEY_IDX_W-1:0] KEY_E          = 5'd17;
    localparam logic [KEY_IDX_W-1:0] KEY_R          = 5'd18;
    localparam logic [KEY_IDX_W-1:0] KEY_T          = 5'd19;
    localparam logic [KEY_IDX_W-1:0] KEY_Y          = 5'd20;
    localparam logic [KEY_IDX_W-1:0] KEY_U          = 5'd21;
    localparam logic [KEY_IDX_W-1:0] KEY_I          = 5'd22;
    localparam logic [KEY_IDX_W-1:0] KEY_O          = 5'd23;
    localparam logic [KEY_IDX_W-1:0] KEY_P          = 5'd24;
    localparam logic [KEY_IDX_W-1:0] KEY_LBRACKET   = 5'd25;
    localparam logic [KEY_IDX_W-1:0] KEY_RBRACKET   = 5'd26;
    localparam logic [KEY_IDX_W-1:0] KEY_BACKSLASH  = 5'd27;
    localparam logic [KEY_IDX_W-1:0] KEY_SPACEBAR   = 5'd28;
    localparam int unsigned          NO_PRESS       = 29;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXTEND = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_e;

endpackage

// File: rtl/ps2_key_state_tracker_if.sv
// Scancode input / key-state output bundle of the PS/2 key state tracker.
// master = byte source and state consumer, slave = the tracker itself.
interface ps2_key_state_tracker_if #(
    parameter int unsigned NUM_KEYS = 30
);
    logic [7:0]          scanByte;
    logic                scanValid;
    logic [NUM_KEYS-1:0] keyStateStorage;
    logic                keyEventValid;
    logic [4:0]          keyEventIndex;
    logic                keyEventMake;

    modport master (
        output scanByte, scanValid,
        input  keyStateStorage, keyEventValid, keyEventIndex, keyEventMake
    );

    modport slave (
        input  scanByte, scanValid,
        output keyStateStorage, keyEventValid, keyEventIndex, keyEventMake
    );
endinterface

// File: rtl/ps2_scancode_to_key_index.sv
// Combinational Set-2 scancode to key index lookup; mapped=0 for any code
// that is not one of the supported keys.
module ps2_scancode_to_key_index
    import ps2_key_state_tracker_pkg::*;
(
    input  logic [7:0]           code,
    output logic [KEY_IDX_W-1:0] index,
    output logic                 mapped
);

    // Table lookup; unmapped codes report index 0 with mapped clear.
    always_comb begin
        index  = '0;
        mapped = 1'b1;
        case (code)
            8'h45: index = KEY_0;
            8'h16: index = KEY_1;
            8'h1E: index = KEY_2;
            8'h26: index = KEY_3;
            8'h25: index = KEY_4;
            8'h2E: index = KEY_5;
            8'h36: index = KEY_6;
            8'h3D: index = KEY_7;
            8'h3E: index = KEY_8;
            8'h46: index = KEY_9;
            8'h0E: index = KEY_TILDE;
            8'h4E: index = KEY_MINUS;
            8'h55: index = KEY_EQUAL;
            8'h66: index = KEY_BACKSPACE;
            8'h0D: index = KEY_TAB;
            8'h15: index = KEY_Q;
            8'h1D: index = KEY_W;
            8'h24: index = KEY_E;
            8'h2D: index = KEY_R;
            8'h2C: index = KEY_T;
            8'h35: index = KEY_Y;
            8'h3C: index = KEY_U;
            8'h43: index = KEY_I;
            8'h44: index = KEY_O;
            8'h4D: index = KEY_P;
            8'h54: index = KEY_LBRACKET;
            8'h5B: index = KEY_RBRACKET;
            8'h5D: index = KEY_BACKSLASH;
            8'h29: index = KEY_SPACEBAR;
            default: mapped = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_state_tracker.sv
// PS/2 Set-2 byte stream to held-key vector plus one-cycle key events.
// Optional build macro: STUCK_KEY_TIMEOUT_EN (force-release all keys after
// TIMEOUT_CYCLES cycles without a received byte).
module ps2_key_state_tracker
    import ps2_key_state_tracker_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = NUMBEROFKEYBOARDINPUTS,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    ps2_key_state_tracker_if.slave  bus
);

    localparam logic [NUM_KEYS-1:0] STORAGE_RST = {1'b1, {(NUM_KEYS-1){1'b0}}};

    ps2_state_e            state_q, state_d;
    logic [NUM_KEYS-1:0]   storage_q, storage_d;
    logic [NUM_KEYS-2:0]   keys_q, keys_d;
    logic                  ev_valid_q, ev_valid_d;
    logic [KEY_IDX_W-1:0]  ev_index_q, ev_index_d;
    logic                  ev_make_q, ev_make_d;

    logic [KEY_IDX_W-1:0]  map_index;
    logic                  map_hit;

`ifdef STUCK_KEY_TIMEOUT_EN
    logic [25:0]           idle_cnt_q, idle_cnt_d;
`endif

    ps2_scancode_to_key_index u_map (
        .code   (bus.scanByte),
        .index  (map_index),
        .mapped (map_hit)
    );

    assign keys_q = storage_q[NUM_KEYS-2:0];

    // Prefix tracking and key set/clear decision for the current byte.
    always_comb begin
        state_d    = state_q;
        keys_d     = keys_q;
        ev_valid_d = 1'b0;
        ev_index_d = ev_index_q;
        ev_make_d  = ev_make_q;
        if (bus.scanValid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.scanByte == PS2_BREAK) begin
                        state_d = ST_BRK;
                    end else if (bus.scanByte == PS2_EXTEND) begin
                        state_d = ST_EXT;
                    end else if (map_hit && !keys_q[map_index]) begin
                        keys_d[map_index] = 1'b1;
                        ev_valid_d        = 1'b1;
                        ev_index_d        = map_index;
                        ev_make_d         = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (bus.scanByte == PS2_BREAK) begin
                        state_d = ST_BRK;
                    end else if (bus.scanByte == PS2_EXTEND) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                        if (map_hit && keys_q[map_index]) begin
                            keys_d[map_index] = 1'b0;
                            ev_valid_d        = 1'b1;
                            ev_index_d        = map_index;
                            ev_make_d         = 1'b0;
                        end
                    end
                end
                ST_EXT: begin
                    state_d = (bus.scanByte == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
`ifdef STUCK_KEY_TIMEOUT_EN
        idle_cnt_d = bus.scanValid ? '0 : ((&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 26'd1);
        // A byte arriving in the same cycle wins over the forced release.
        if (!bus.scanValid && (idle_cnt_q >= 26'(TIMEOUT_CYCLES)) && (|keys_q)) begin
            keys_d  = '0;
            state_d = ST_IDLE;
        end
`endif
        storage_d = {~|keys_d, keys_d};
    end

    // Register FSM state, key vector (with derived noPress) and event outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            storage_q  <= STORAGE_RST;
            ev_valid_q <= 1'b0;
            ev_index_q <= '0;
            ev_make_q  <= 1'b0;
`ifdef STUCK_KEY_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            storage_q  <= storage_d;
            ev_valid_q <= ev_valid_d;
            ev_index_q <= ev_index_d;
            ev_make_q  <= ev_make_d;
`ifdef STUCK_KEY_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
`endif
        end
    end

    assign bus.keyStateStorage = storage_q;
    assign bus.keyEventValid   = ev_valid_q;
    assign bus.keyEventIndex   = ev_index_q;
    assign bus.keyEventMake    = ev_make_q;

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Directed scoreboard bench for ps2_key_state_tracker: expected key events
// are queued by the stimulus, a negedge monitor pops and compares them.
module tb_ps2_key_state_tracker;

    localparam int unsigned NK = 30;
    localparam logic [NK-1:0] NOPRESS = 30'h2000_0000;

    typedef struct packed {
        logic [4:0] idx;
        logic       make;
    } ev_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    ev_t  exp_q[$];

    ps2_key_state_tracker_if #(.NUM_KEYS(NK)) bus ();

    ps2_key_state_tracker #(
        .NUM_KEYS       (NK),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.scanByte  = b;
        bus.scanValid = 1'b1;
        @(negedge clk);
        bus.scanValid = 1'b0;
    endtask

    task automatic expect_ev(input logic [4:0] idx, input logic make);
        ev_t e;
        e.idx  = idx;
        e.make = make;
        exp_q.push_back(e);
    endtask

    // Monitor: every event pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.keyEventValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got idx=%0d make=%0d expected no event",
                         bus.keyEventIndex, bus.keyEventMake);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_index", 32'(bus.keyEventIndex), 32'(e.idx));
                chk("event_make", 32'(bus.keyEventMake), 32'(e.make));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.scanByte  = 8'h00;
        bus.scanValid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("reset_vector", 32'(bus.keyStateStorage), 32'(NOPRESS));
        chk("reset_evvalid", 32'(bus.keyEventValid), 32'd0);
        chk("reset_evindex", 32'(bus.keyEventIndex), 32'd0);
        chk("reset_evmake", 32'(bus.keyEventMake), 32'd0);

        // Make of Q
        expect_ev(5'd15, 1'b1);
        send(8'h15);
        chk("q_make_vec", 32'(bus.keyStateStorage), 32'h0000_8000);

        // Typematic repeats then release of Q
        send(8'h15);
        send(8'h15);
        chk("typematic_vec", 32'(bus.keyStateStorage), 32'h0000_8000);
        send(8'hF0);
        chk("brk_prefix_hold", 32'(bus.keyStateStorage), 32'h0000_8000);
        expect_ev(5'd15, 1'b0);
        send(8'h15);
        chk("q_break_vec", 32'(bus.keyStateStorage), 32'(NOPRESS));

        // Tab and W together, then release tab only
        expect_ev(5'd14, 1'b1);
        send(8'h0D);
        expect_ev(5'd16, 1'b1);
        send(8'h1D);
        chk("two_keys_vec", 32'(bus.keyStateStorage), 32'h0001_4000);
        send(8'hF0);
        expect_ev(5'd14, 1'b0);
        send(8'h0D);
        chk("tab_released_vec", 32'(bus.keyStateStorage), 32'h0001_0000);
        send(8'hF0);
        expect_ev(5'd16, 1'b0);
        send(8'h1D);
        chk("w_released_vec", 32'(bus.keyStateStorage), 32'(NOPRESS));

        // Extended break and unmapped codes leave held Q untouched
        expect_ev(5'd15, 1'b1);
        send(8'h15);
        send(8'hE0);
        send(8'hF0);
        send(8'h15);
        chk("ext_brk_ignored", 32'(bus.keyStateStorage), 32'h0000_8000);
        send(8'h7E);
        chk("unmapped_ignored", 32'(bus.keyStateStorage), 32'h0000_8000);
        send(8'hE0);
        send(8'h45);
        chk("ext_make_ignored", 32'(bus.keyStateStorage), 32'h0000_8000);
        send(8'hF0);
        send(8'h16);
        chk("break_of_clear_key", 32'(bus.keyStateStorage), 32'h0000_8000);

        // Reset after F0 releases everything silently; next 15 is a make
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midseq_reset_vec", 32'(bus.keyStateStorage), 32'(NOPRESS));
        expect_ev(5'd15, 1'b1);
        send(8'h15);
        chk("after_reset_make", 32'(bus.keyStateStorage), 32'h0000_8000);

        // Boundary indices 0 and 28, repeated F0, BRK->EXT, BRK->other
        expect_ev(5'd0, 1'b1);
        send(8'h45);
        expect_ev(5'd28, 1'b1);
        send(8'h29);
        chk("idx0_idx28_vec", 32'(bus.keyStateStorage), 32'h1000_8001);
        send(8'hF0);
        send(8'hF0);
        expect_ev(5'd28, 1'b0);
        send(8'h29);
        chk("double_f0_break", 32'(bus.keyStateStorage), 32'h0000_8001);
        send(8'hF0);
        send(8'hE0);
        send(8'h45);
        chk("brk_then_ext", 32'(bus.keyStateStorage), 32'h0000_8001);
        send(8'hF0);
        send(8'h7E);
        send(8'h45);
        chk("brk_other_then_repeat", 32'(bus.keyStateStorage), 32'h0000_8001);
        send(8'hF0);
        expect_ev(5'd0, 1'b0);
        send(8'h45);
        send(8'hF0);
        expect_ev(5'd15, 1'b0);
        send(8'h15);
        chk("all_released", 32'(bus.keyStateStorage), 32'(NOPRESS));

`ifdef STUCK_KEY_TIMEOUT_EN
        expect_ev(5'd28, 1'b1);
        send(8'h29);
        chk("timeout_pre_vec", 32'(bus.keyStateStorage), 32'h1000_0000);
        repeat (90) @(negedge clk);
        chk("timeout_not_yet", 32'(bus.keyStateStorage), 32'h1000_0000);
        repeat (20) @(negedge clk);
        chk("timeout_vec", 32'(bus.keyStateStorage), 32'(NOPRESS));
        expect_ev(5'd28, 1'b1);
        send(8'h29);
        chk("after_timeout_make", 32'(bus.keyStateStorage), 32'h1000_0000);
`endif

        repeat (4) @(negedge clk);
        chk("all_events_seen", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
